instruction_fetch: RTL

Instruction fetch stage of the multi-cycle RV32I core, directly upstream of the immediate generator and decoder. Holds the PC and on a fetch command from the control FSM issues a single-word read over a valid/ready request channel, then waits for the response. Latches the returned word into the instruction register that drives current_instruction to the immediate generator and decoder. Also keeps old_pc, the address of the latched instruction, for branch and jump target computation.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_watchdog.sv | 28 ++
 rtl/instruction_fetch.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_TIMEOUT  = 2'd2
    } fault_cause_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/fetch_watchdog.sv
// WAIT-state cycle counter; expired is high in the WAIT cycle that hits TIMEOUT_CYCLES.
module fetch_watchdog
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic in_wait,
    output logic expired
);
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] cnt;

    // Held at zero outside WAIT so every entry starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!in_wait)
            cnt <= '0;
        else if (!expired)
            cnt <= cnt + CW'(1);
    end

    assign expired = in_wait && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single-word valid/ready memory read, instruction register.
// Optional WAIT timeout under `define FETCH_TIMEOUT_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        pc_write,
    input  logic [31:0] pc_next,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic [31:0] current_instruction,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause
);
    fetch_state_t state, state_nxt;
    fault_cause_t cause_q;
    logic         wd_expired;
    logic         aligned;

    assign aligned = (pc[1:0] == 2'b00);

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .in_wait (state == WAIT),
        .expired (wd_expired)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_start && aligned) state_nxt = REQ;
            REQ:     if (mem_req_ready) state_nxt = WAIT;
            WAIT:    if (mem_rsp_valid || wd_expired) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational from state so async reset drops the request at once.
    assign mem_req_valid = (state == REQ);
    assign busy          = (state != IDLE);
    assign fault_cause   = cause_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                  <= RESET_PC;
            old_pc              <= RESET_PC;
            current_instruction <= NOP_INSTR;
            mem_addr            <= '0;
            instr_valid         <= 1'b0;
            fetch_fault         <= 1'b0;
            cause_q             <= FAULT_NONE;
        end else begin
            instr_valid <= 1'b0;
            if (pc_write)
                pc <= pc_next;
            if (state == IDLE && fetch_start) begin
                if (aligned) begin
                    mem_addr    <= pc;
                    fetch_fault <= 1'b0;
                    cause_q     <= FAULT_NONE;
                end else begin
                    fetch_fault <= 1'b1;
                    cause_q     <= FAULT_MISALIGN;
                end
            end
            // A response coinciding with expiry still wins.
            if (state == WAIT) begin
                if (mem_rsp_valid) begin
                    current_instruction <= mem_rsp_data;
                    old_pc              <= mem_addr;
                    instr_valid         <= 1'b1;
                end else if (wd_expired) begin
                    fetch_fault <= 1'b1;
                    cause_q     <= FAULT_TIMEOUT;
                end
            end
        end
    end

endmodule
